// File: rtl/conv_pkg.sv
// Shared constants and FSM state type for the 7x7/3x3 convolution engine and its frame feeder.
package conv_pkg;
  localparam int IFM_DIM = 7;
  localparam int K_DIM   = 3;
  localparam int DATA_W  = 16;
  localparam int OFM_W   = 36;
  localparam int N_IFM   = IFM_DIM * IFM_DIM;
  localparam int N_W     = K_DIM * K_DIM;
  localparam int N_OFM   = (IFM_DIM - K_DIM + 1) * (IFM_DIM - K_DIM + 1);
  localparam int TIMEOUT = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } state_t;
endpackage

// File: rtl/conv_ofm_collector.sv
// Captures returned OFM beats into a 25-entry result buffer and tracks DRAIN inactivity.
// Beats beyond the buffer size are dropped; the read port is combinational.
module conv_ofm_collector
  import conv_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             capture_en,
  input  logic             drain,
  input  logic             out_valid,
  input  logic [OFM_W-1:0] Out_OFM,
  input  logic [4:0]       rd_addr,
  output logic [OFM_W-1:0] rd_data,
  output logic [5:0]       ofm_count,
  output logic             full,
  output logic             timed_out
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [OFM_W-1:0] result [N_OFM];
  logic [TW-1:0]    idle_cnt;
  logic             capture;

  assign capture   = capture_en && out_valid && (ofm_count < 6'(N_OFM));
  assign full      = (ofm_count == 6'(N_OFM));
  assign timed_out = (idle_cnt >= TW'(TIMEOUT_CYC));
  assign rd_data   = (rd_addr < 5'(N_OFM)) ? result[rd_addr] : '0;

  // Result storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (capture) result[ofm_count[4:0]] <= Out_OFM;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ofm_count <= '0;
      idle_cnt  <= '0;
    end else if (clear) begin
      ofm_count <= '0;
      idle_cnt  <= '0;
    end else begin
      if (capture) ofm_count <= ofm_count + 6'd1;
      if (out_valid)  idle_cnt <= '0;
      else if (drain) idle_cnt <= idle_cnt + TW'(1);
    end
  end
endmodule

// File: rtl/conv_frame_feeder.sv
// Streams one stored IFM frame plus 3x3 kernel to the convolution engine and collects its OFM beats.
// First beat one cycle after start; all engine-side outputs are registered.
module conv_frame_feeder
  import conv_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic              cfg_sel,
  input  logic [5:0]        cfg_addr,
  input  logic [DATA_W-1:0] cfg_wdata,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              timeout_err,
  output logic              in_valid,
  output logic [DATA_W-1:0] In_IFM_1,
  output logic              weight_valid,
  output logic [DATA_W-1:0] In_Weight_1,
  input  logic              out_valid,
  input  logic [OFM_W-1:0]  Out_OFM,
  input  logic [4:0]        rd_addr,
  output logic [OFM_W-1:0]  rd_data,
  output logic [5:0]        ofm_count
);
  state_t            state;
  logic [5:0]        idx;
  logic [5:0]        beat_idx;
  logic              emit;
  logic              launch;
  logic              full;
  logic              timed_out;
  logic [DATA_W-1:0] ifm_mem [N_IFM];
  logic [DATA_W-1:0] w_mem   [N_W];

  assign launch   = (state == IDLE) && start;
  // The start edge already issues beat 0 so the first beat lands the cycle after start.
  assign emit     = launch || (state == STREAM);
  assign beat_idx = (state == STREAM) ? idx : 6'd0;

  always_ff @(posedge clk) begin
    if (cfg_we && state == IDLE) begin
      if (!cfg_sel && cfg_addr < 6'(N_IFM)) ifm_mem[cfg_addr] <= cfg_wdata;
      if (cfg_sel && cfg_addr < 6'(N_W))    w_mem[cfg_addr[3:0]] <= cfg_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      idx          <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      timeout_err  <= 1'b0;
      in_valid     <= 1'b0;
      weight_valid <= 1'b0;
      In_IFM_1     <= '0;
      In_Weight_1  <= '0;
    end else begin
      done <= 1'b0;

      if (emit) begin
        in_valid <= 1'b1;
        In_IFM_1 <= ifm_mem[beat_idx];
        idx      <= beat_idx + 6'd1;
        if (beat_idx < 6'(N_W)) begin
          weight_valid <= 1'b1;
          In_Weight_1  <= w_mem[beat_idx[3:0]];
        end else begin
          weight_valid <= 1'b0;
          In_Weight_1  <= '0;
        end
      end else begin
        in_valid     <= 1'b0;
        weight_valid <= 1'b0;
        In_Weight_1  <= '0;
      end

      case (state)
        IDLE: begin
          if (start) begin
            state       <= STREAM;
            busy        <= 1'b1;
            timeout_err <= 1'b0;
          end
        end
        STREAM: begin
          if (beat_idx == 6'(N_IFM - 1)) state <= DRAIN;
        end
        DRAIN: begin
          if (full || timed_out) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
            if (!full) timeout_err <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  conv_ofm_collector #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_collector (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (launch),
    .capture_en (state == STREAM || state == DRAIN),
    .drain      (state == DRAIN),
    .out_valid  (out_valid),
    .Out_OFM    (Out_OFM),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .ofm_count  (ofm_count),
    .full       (full),
    .timed_out  (timed_out)
  );
endmodule

// File: tb/tb_conv_frame_feeder.sv
// Bench for conv_frame_feeder: acts as host and as a convolution-engine stub, with a reference convolution model.
module tb_conv_frame_feeder;
  import conv_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cfg_we;
  logic              cfg_sel;
  logic [5:0]        cfg_addr;
  logic [DATA_W-1:0] cfg_wdata;
  logic              start;
  logic              busy;
  logic              done;
  logic              timeout_err;
  logic              in_valid;
  logic [DATA_W-1:0] In_IFM_1;
  logic              weight_valid;
  logic [DATA_W-1:0] In_Weight_1;
  logic              out_valid;
  logic [OFM_W-1:0]  Out_OFM;
  logic [4:0]        rd_addr;
  logic [OFM_W-1:0]  rd_data;
  logic [5:0]        ofm_count;

  always #5 clk = ~clk;

  conv_frame_feeder dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_we       (cfg_we),
    .cfg_sel      (cfg_sel),
    .cfg_addr     (cfg_addr),
    .cfg_wdata    (cfg_wdata),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .timeout_err  (timeout_err),
    .in_valid     (in_valid),
    .In_IFM_1     (In_IFM_1),
    .weight_valid (weight_valid),
    .In_Weight_1  (In_Weight_1),
    .out_valid    (out_valid),
    .Out_OFM      (Out_OFM),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .ofm_count    (ofm_count)
  );

  int tests = 0;
  int fails = 0;
  int done_seen = 0;

  // Host-side image of what was written, and what the engine stub actually received.
  logic [DATA_W-1:0] h_ifm   [N_IFM];
  logic [DATA_W-1:0] h_w     [N_W];
  logic [DATA_W-1:0] cap_ifm [N_IFM];
  logic [DATA_W-1:0] cap_w   [N_W];

  always @(negedge clk) if (done === 1'b1) done_seen++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Valid 3x3 convolution, output (r,c) over a 5x5 grid, full 36-bit precision.
  function automatic logic [OFM_W-1:0] conv(input int o, input bit from_cap);
    int r;
    int c;
    logic [OFM_W-1:0] s;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    r = o / 5;
    c = o % 5;
    s = '0;
    for (int kr = 0; kr < K_DIM; kr++) begin
      for (int kc = 0; kc < K_DIM; kc++) begin
        a = from_cap ? cap_ifm[(r + kr) * IFM_DIM + c + kc] : h_ifm[(r + kr) * IFM_DIM + c + kc];
        b = from_cap ? cap_w[kr * K_DIM + kc] : h_w[kr * K_DIM + kc];
        s = s + OFM_W'(a) * OFM_W'(b);
      end
    end
    return s;
  endfunction

  task automatic wr(input logic sel, input int addr, input logic [DATA_W-1:0] data);
    @(negedge clk);
    cfg_we    = 1'b1;
    cfg_sel   = sel;
    cfg_addr  = 6'(addr);
    cfg_wdata = data;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic load(input int mode);
    for (int i = 0; i < N_IFM; i++) begin
      h_ifm[i] = (mode == 0) ? 16'd1 : (mode == 1) ? DATA_W'(i) : 16'hFFFF;
      wr(1'b0, i, h_ifm[i]);
    end
    for (int i = 0; i < N_W; i++) begin
      h_w[i] = (mode == 0) ? 16'd1 : (mode == 1) ? ((i == 4) ? 16'd1 : 16'd0) : 16'hFFFF;
      wr(1'b1, i, h_w[i]);
    end
    // Out-of-range writes must land nowhere.
    wr(1'b0, 55, 16'h7777);
    wr(1'b1, 12, 16'h7777);
  endtask

  task automatic read_result(input int i);
    rd_addr = 5'(i);
    #1;
  endtask

  task automatic run_frame(input int n_beats, input int rst_at, input bit disturb, input bit exp_to);
    int n_keep;
    n_keep = (n_beats < N_OFM) ? n_beats : N_OFM;
    done_seen = 0;
    @(negedge clk);
    start = 1'b1;
    for (int k = 0; k < 51; k++) begin
      @(negedge clk);
      if (k == 0) start = 1'b0;
      if (disturb && k == 10) begin
        start = 1'b1; cfg_we = 1'b1; cfg_sel = 1'b0; cfg_addr = 6'd0; cfg_wdata = 16'hDEAD;
      end
      if (disturb && k == 11) begin
        start = 1'b0; cfg_we = 1'b0;
      end
      if (k == rst_at) begin
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_in_valid", 64'(in_valid), 64'd0);
        check("rst_ofm_count", 64'(ofm_count), 64'd0);
        return;
      end
      check("in_valid", 64'(in_valid), 64'(k < N_IFM));
      check("weight_valid", 64'(weight_valid), 64'(k < N_W));
      check("busy", 64'(busy), 64'd1);
      if (k < N_IFM) begin
        cap_ifm[k] = In_IFM_1;
        check("ifm_dat", 64'(In_IFM_1), 64'(h_ifm[k]));
        check("timeout_err_clr", 64'(timeout_err), 64'd0);
        if (k < N_W) begin
          cap_w[k] = In_Weight_1;
          check("w_dat", 64'(In_Weight_1), 64'(h_w[k]));
        end else begin
          check("w_zero", 64'(In_Weight_1), 64'd0);
        end
      end
    end
    // Engine stub: return beats computed from what it actually received.
    for (int b = 0; b < n_beats; b++) begin
      @(negedge clk);
      out_valid = 1'b1;
      Out_OFM   = (b < N_OFM) ? conv(b, 1'b1) : 36'hBAD_BAD_BAD;
    end
    @(negedge clk);
    out_valid = 1'b0;
    for (int w = 0; w < 300 && done_seen == 0; w++) @(negedge clk);
    @(negedge clk);
    check("done_pulses", 64'(done_seen), 64'd1);
    check("done_low", 64'(done), 64'd0);
    check("busy_after", 64'(busy), 64'd0);
    check("timeout_err", 64'(timeout_err), 64'(exp_to));
    check("ofm_count", 64'(ofm_count), 64'(n_keep));
    for (int i = 0; i < n_keep; i++) begin
      read_result(i);
      check("result", 64'(rd_data), 64'(conv(i, 1'b0)));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; cfg_we = 1'b0; cfg_sel = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    start = 1'b0; out_valid = 1'b0; Out_OFM = '0; rd_addr = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_timeout_err", 64'(timeout_err), 64'd0);
    check("reset_in_valid", 64'(in_valid), 64'd0);
    check("reset_weight_valid", 64'(weight_valid), 64'd0);
    check("reset_ifm", 64'(In_IFM_1), 64'd0);
    check("reset_w", 64'(In_Weight_1), 64'd0);
    check("reset_ofm_count", 64'(ofm_count), 64'd0);
    rst_n = 1'b1;

    load(0);
    run_frame(25, -1, 1'b0, 1'b0);
    read_result(0);
    check("lit_ones_r0", 64'(rd_data), 64'd9);
    read_result(24);
    check("lit_ones_r24", 64'(rd_data), 64'd9);

    load(1);
    run_frame(25, -1, 1'b1, 1'b0);
    read_result(0);
    check("lit_ramp_r0", 64'(rd_data), 64'd8);
    read_result(5);
    check("lit_ramp_r5", 64'(rd_data), 64'd15);
    read_result(24);
    check("lit_ramp_r24", 64'(rd_data), 64'd40);

    // Same data again: proves the busy-time write was dropped; extra beats are ignored.
    run_frame(30, -1, 1'b0, 1'b0);

    load(2);
    run_frame(25, -1, 1'b0, 1'b0);
    read_result(12);
    check("lit_max_r12", 64'(rd_data), 64'h8_FFEE_0009);

    run_frame(10, -1, 1'b0, 1'b1);
    @(negedge clk);
    out_valid = 1'b1;
    Out_OFM   = 36'h123;
    @(negedge clk);
    out_valid = 1'b0;
    @(negedge clk);
    check("idle_beat_ignored", 64'(ofm_count), 64'd10);

    load(1);
    run_frame(25, 20, 1'b0, 1'b0);
    run_frame(25, -1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
